// File: rtl/j_mavg_if.sv
// Sample-stream bundle for the j moving-average block: the producer drives
// samples and clear, the averager returns the windowed result and fill status.
interface j_mavg_if #(
  parameter int WIN_LOG2 = 2
);
  // Handshake: in_j is taken on any rising edge with in_valid=1 (no ready, the
  // averager always accepts); out_valid is a one-cycle pulse qualifying out_j/out_sum.
  logic                  in_valid;
  logic [7:0]            in_j;
  logic                  clear;
  logic                  out_valid;
  logic [7:0]            out_j;
  logic [8+WIN_LOG2-1:0] out_sum;
  logic                  filled;

  modport master (
    output in_valid, in_j, clear,
    input  out_valid, out_j, out_sum, filled
  );

  modport slave (
    input  in_valid, in_j, clear,
    output out_valid, out_j, out_sum, filled
  );
endinterface

// File: rtl/j_mavg.sv
// Moving average over the last 2**WIN_LOG2 unsigned 8-bit samples, with a
// FILL phase before the first full window and a synchronous flush.
module j_mavg #(
  parameter int WIN_LOG2 = 2
) (
  input  logic     clock,
  input  logic     reset,
  j_mavg_if.slave  bus,
  output logic     state_dbg
);
  localparam int N  = 1 << WIN_LOG2;
  localparam int SW = 8 + WIN_LOG2;
  localparam int CW = WIN_LOG2 + 1;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [7:0]    win [N];
  logic [SW-1:0] sum, sum_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept, full_after;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  // Next-state logic: clear always wins and RUN is only left through it
  always_comb begin
    state_nxt = state;
    if (bus.clear)                 state_nxt = FILL;
    else if (accept && full_after) state_nxt = RUN;
  end

  // Output/datapath decode for the accepted sample
  always_comb begin
    accept     = bus.in_valid && !bus.clear;
    cnt_nxt    = cnt;
    full_after = (state == RUN);
    // The oldest entry only leaves the sum once the window is full
    sum_nxt    = sum + SW'(bus.in_j) - ((state == RUN) ? SW'(win[N-1]) : SW'(0));
    if (state == FILL) begin
      cnt_nxt = cnt + CW'(1);
      if (cnt_nxt == CW'(N)) full_after = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      sum           <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_j     <= '0;
      bus.out_sum   <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      sum           <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_j     <= '0;
      bus.out_sum   <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      if (accept) begin
        win[0] <= bus.in_j;
        for (int i = 1; i < N; i++) win[i] <= win[i-1];
        sum <= sum_nxt;
        cnt <= cnt_nxt;
        if (full_after) begin
          bus.out_valid <= 1'b1;
          bus.out_sum   <= sum_nxt;
          bus.out_j     <= sum_nxt[SW-1:WIN_LOG2];
        end
      end
    end
  end

  assign bus.filled = (state == RUN);
  assign state_dbg  = state;
endmodule

// File: tb/tb_j_mavg.sv
// Directed bench for j_mavg: window-of-4 and window-of-2 instances checked
// against hand-computed sums and averages.
module tb_j_mavg;
  logic clock;
  logic reset;
  logic st2, st1;
  int   tests;
  int   failed;

  j_mavg_if #(.WIN_LOG2(2)) b2();
  j_mavg_if #(.WIN_LOG2(1)) b1();

  j_mavg #(.WIN_LOG2(2)) u2 (.clock(clock), .reset(reset), .bus(b2), .state_dbg(st2));
  j_mavg #(.WIN_LOG2(1)) u1 (.clock(clock), .reset(reset), .bus(b1), .state_dbg(st1));

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drivers: present one cycle of input, then sample #1 after the edge
  task automatic step2(input logic v, input logic [7:0] d, input logic c);
    @(negedge clock);
    b2.in_valid = v; b2.in_j = d; b2.clear = c;
    @(posedge clock); #1;
  endtask

  task automatic step1(input logic v, input logic [7:0] d, input logic c);
    @(negedge clock);
    b1.in_valid = v; b1.in_j = d; b1.clear = c;
    @(posedge clock); #1;
  endtask

  task automatic out2(input string tag, input logic ov, input logic [9:0] s, input logic [7:0] j);
    chk({tag, "_ov"}, 32'(b2.out_valid), 32'(ov));
    chk({tag, "_sum"}, 32'(b2.out_sum), 32'(s));
    chk({tag, "_j"}, 32'(b2.out_j), 32'(j));
  endtask

  initial begin
    tests = 0; failed = 0;
    reset = 1'b1;
    b2.in_valid = 0; b2.in_j = 0; b2.clear = 0;
    b1.in_valid = 0; b1.in_j = 0; b1.clear = 0;
    #1 reset = 1'b0;
    #2;
    out2("rst", 1'b0, 10'd0, 8'd0);
    chk("rst_filled", 32'(b2.filled), 32'd0);
    chk("rst_state", 32'(st2), 32'd0);
    @(negedge clock); reset = 1'b1;

    // Fill: 10,20,30,40
    step2(1, 8'd10, 0); chk("fill1_ov", 32'(b2.out_valid), 0);
    step2(1, 8'd20, 0); chk("fill2_ov", 32'(b2.out_valid), 0);
    step2(1, 8'd30, 0); chk("fill3_ov", 32'(b2.out_valid), 0);
    chk("fill3_filled", 32'(b2.filled), 0);
    step2(1, 8'd40, 0); out2("fill4", 1'b1, 10'd100, 8'd25);
    chk("fill4_filled", 32'(b2.filled), 1);

    // Slide, with idle gaps
    step2(0, 8'd0, 0);  out2("gap0", 1'b0, 10'd100, 8'd25);
    step2(1, 8'd50, 0); out2("slide50", 1'b1, 10'd140, 8'd35);
    step2(0, 8'd0, 0);  chk("gap1_ov", 32'(b2.out_valid), 0);
    step2(0, 8'd0, 0);  chk("gap2_ov", 32'(b2.out_valid), 0);
    step2(1, 8'd60, 0); out2("slide60", 1'b1, 10'd180, 8'd45);
    step2(0, 8'd0, 0);  chk("gap3_ov", 32'(b2.out_valid), 0);
    step2(1, 8'd70, 0); out2("slide70", 1'b1, 10'd220, 8'd55);

    // Back-to-back maximum samples
    step2(1, 8'd255, 0); out2("max1", 1'b1, 10'd435, 8'd108);
    step2(1, 8'd255, 0); out2("max2", 1'b1, 10'd640, 8'd160);
    step2(1, 8'd255, 0); out2("max3", 1'b1, 10'd835, 8'd208);
    step2(1, 8'd255, 0); out2("max4", 1'b1, 10'd1020, 8'd255);
    // Truncation
    step2(1, 8'd1, 0); out2("tr1", 1'b1, 10'd766, 8'd191);
    step2(1, 8'd1, 0); out2("tr2", 1'b1, 10'd512, 8'd128);
    step2(1, 8'd1, 0); out2("tr3", 1'b1, 10'd258, 8'd64);
    step2(1, 8'd2, 0); out2("tr4", 1'b1, 10'd5, 8'd1);

    // Clear: flush, 3 samples, clear colliding with 99, then 4,4,4,8
    step2(0, 8'd0, 1); out2("clr0", 1'b0, 10'd0, 8'd0);
    chk("clr0_filled", 32'(b2.filled), 0);
    step2(1, 8'd7, 0); step2(1, 8'd7, 0); step2(1, 8'd7, 0);
    chk("pre_clr_ov", 32'(b2.out_valid), 0);
    step2(1, 8'd99, 1); out2("clr99", 1'b0, 10'd0, 8'd0);
    chk("clr99_filled", 32'(b2.filled), 0);
    chk("clr99_state", 32'(st2), 0);
    step2(1, 8'd4, 0); step2(1, 8'd4, 0); step2(1, 8'd4, 0);
    chk("refill3_ov", 32'(b2.out_valid), 0);
    step2(1, 8'd8, 0); out2("refill4", 1'b1, 10'd20, 8'd5);
    chk("refill4_filled", 32'(b2.filled), 1);

    // Asynchronous reset mid-run
    step2(0, 8'd0, 0);
    #2 reset = 1'b0;
    #1;
    out2("arst", 1'b0, 10'd0, 8'd0);
    chk("arst_filled", 32'(b2.filled), 0);
    @(negedge clock); reset = 1'b1;
    step2(1, 8'd1, 0); chk("post1_ov", 32'(b2.out_valid), 0);
    step2(1, 8'd2, 0); chk("post2_ov", 32'(b2.out_valid), 0);
    step2(1, 8'd3, 0); chk("post3_ov", 32'(b2.out_valid), 0);
    step2(1, 8'd4, 0); out2("post4", 1'b1, 10'd10, 8'd2);
    step2(0, 8'd0, 0);

    // Window of two
    step1(1, 8'd3, 0); chk("w1_s1_ov", 32'(b1.out_valid), 0);
    step1(1, 8'd4, 0);
    chk("w1_s2_ov", 32'(b1.out_valid), 1);
    chk("w1_s2_sum", 32'(b1.out_sum), 7);
    chk("w1_s2_j", 32'(b1.out_j), 3);
    chk("w1_s2_filled", 32'(b1.filled), 1);
    step1(1, 8'd9, 0);
    chk("w1_s3_ov", 32'(b1.out_valid), 1);
    chk("w1_s3_sum", 32'(b1.out_sum), 13);
    chk("w1_s3_j", 32'(b1.out_j), 6);
    step1(0, 8'd0, 0);
    chk("w1_idle_ov", 32'(b1.out_valid), 0);
    chk("w1_idle_sum", 32'(b1.out_sum), 13);

    // Report
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/j_mavg.md
J_MAVG -- requirements
Module: j_mavg

Interface
REQ-001 SHALL have parameter: WIN_LOG2, 2, log2 of window length N (N = 2**WIN_LOG2); legal range 1..4.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 SHALL have port: in_valid  input  1  in_j is sampled at the rising clock edge when in_valid=1; no backpressure.
REQ-005 SHALL have port: in_j  input  8  unsigned input sample.
REQ-006 SHALL have port: clear  input  1  synchronous window flush.
REQ-007 SHALL have port: out_valid  output  1  one-cycle pulse; out_j and out_sum are valid when out_valid=1.
REQ-008 SHALL have port: out_j  output  8  window average; drives the downstream valid/j stage.
REQ-009 SHALL have port: out_sum  output  8+WIN_LOG2  window sum.
REQ-010 SHALL have port: filled  output  1  1 when the window holds N samples (state RUN).

Function
REQ-011 SHALL hold an N-entry sample shift register, a running sum of width 8+WIN_LOG2, and a fill counter of width WIN_LOG2+1.
REQ-012 SHALL implement state machine FILL -> RUN; FILL is entered at reset and on clear.
REQ-013 FILL, in_valid=1, clear=0: shift in_j into the window, sum += in_j, increment the fill counter.
REQ-014 FILL: go to RUN on the accepted sample that brings the fill count to N.
REQ-015 RUN, in_valid=1, clear=0: shift in_j in and drop the oldest sample; sum = sum + in_j - oldest; width is exact, so no overflow is possible.
REQ-016 RUN SHALL be left only via clear or reset.
REQ-017 out_valid SHALL be 1 in the cycle after an accepted sample, but only if the window is full after that sample; this covers the N-th sample in FILL and every sample in RUN.
REQ-018 Latency SHALL be 1 clock, from the in_valid edge to out_valid high.
REQ-019 On an out_valid pulse: out_sum = updated sum; out_j = out_sum >> WIN_LOG2, truncated, never rounded.
REQ-020 in_valid=0 SHALL leave window, sum and state unchanged; out_valid=0; out_j and out_sum hold their last values.
REQ-021 clear=1 SHALL take priority over in_valid, and a sample presented in that cycle is discarded.
REQ-022 clear=1 SHALL zero the window, sum and fill counter, set state FILL, set filled=0, and set out_valid=0 on the next cycle.
REQ-023 clear SHALL zero out_j and out_sum.
REQ-024 Back-to-back in_valid=1 on every cycle SHALL produce out_valid=1 on every cycle once RUN is reached.
REQ-025 filled SHALL be registered; it goes to 1 in the same cycle as the first out_valid pulse.

Reset
REQ-026 reset=0 SHALL immediately and asynchronously force: state FILL, window entries 0, sum 0, fill count 0, out_valid 0, out_j 0, out_sum 0, filled 0.
REQ-027 Release of reset SHALL take effect at the first rising clock edge with reset=1; there is no extra settling cycle.
REQ-028 Reset asserted mid-operation SHALL abandon the partial window; after release, N new samples are needed before out_valid.

Verification
REQ-029 Fill: WIN_LOG2=2, samples 10,20,30,40 on consecutive cycles -> out_valid only the cycle after 40, with out_sum=100, out_j=25, filled=1.
REQ-030 Slide: continue with 50 -> out_sum=140, out_j=35; with gaps of in_valid=0 inserted between samples -> identical values, no out_valid during gaps.
REQ-031 Max/truncation: four 255 samples -> out_sum=1020, out_j=255; samples 1,1,1,2 -> out_sum=5, out_j=1.
REQ-032 Clear: clear=1 after 3 samples, in the same cycle as in_valid=1 with value 99 -> 99 ignored, filled=0; the next 4 samples (4,4,4,8) -> out_sum=20, out_j=5.
REQ-033 Reset mid-run: in RUN, reset=0 between clock edges -> all outputs 0 immediately; after release, no out_valid until 4 new samples.
REQ-034 WIN_LOG2=1: samples 3,4 -> out_sum=7, out_j=3; next sample 9 -> out_sum=13, out_j=6.
